// File: rtl/maze_game_sequencer_if.sv
// Controller-side bundle: start button and pointer flags in, pointer restart, overlay selects and status out.
interface maze_game_sequencer_if;
  logic       start_btn;
  logic       lim_ok;
  logic       lim_win;
  logic       ptr_reset;
  logic       play_en;
  logic       scare_on;
  logic       win_on;
  logic [2:0] state;
  logic       tick;
  logic [3:0] crash_cnt;

  modport master (
    input  start_btn, lim_ok, lim_win,
    output ptr_reset, play_en, scare_on, win_on, state, tick, crash_cnt
  );

  modport slave (
    output start_btn, lim_ok, lim_win,
    input  ptr_reset, play_en, scare_on, win_on, state, tick, crash_cnt
  );
endinterface

// File: rtl/maze_game_sequencer.sv
// Maze round controller IDLE->ARM->PLAY->SCARE/WIN->IDLE, pointer flags sampled on a prescaled tick; all outputs registered.
// Define GAME_TIMEOUT_EN to add a PLAY time limit that ends the round as a crash.
module maze_game_sequencer #(
  parameter int TICK_DIV      = 900000,
  parameter int ARM_CYCLES    = 4,
  parameter int HIT_FILTER    = 3,
  parameter int SCARE_TICKS   = 180,
  parameter int WIN_TICKS     = 120,
  parameter int TIMEOUT_TICKS = 3600
) (
  input logic                   clk,
  input logic                   reset,
  maze_game_sequencer_if.master bus
);

  localparam int DW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int AW       = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;
  localparam int MW       = (HIT_FILTER > 1) ? $clog2(HIT_FILTER) : 1;
  localparam int HOLD_MAX = (SCARE_TICKS > WIN_TICKS) ? SCARE_TICKS : WIN_TICKS;
  localparam int HW       = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

  localparam logic [DW-1:0] DIV_LAST   = DW'(TICK_DIV - 1);
  localparam logic [AW-1:0] ARM_LAST   = AW'(ARM_CYCLES - 1);
  localparam logic [MW-1:0] MISS_LAST  = MW'(HIT_FILTER - 1);
  localparam logic [HW-1:0] SCARE_LAST = HW'(SCARE_TICKS - 1);
  localparam logic [HW-1:0] WIN_LAST   = HW'(WIN_TICKS - 1);

`ifdef GAME_TIMEOUT_EN
  localparam int            TW      = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_TICKS - 1);
`endif

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    PLAY  = 3'd2,
    SCARE = 3'd3,
    WIN   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    sync_q, sync_d;
  logic [DW-1:0] div_q, div_d;
  logic [AW-1:0] arm_cnt_q, arm_cnt_d;
  logic [MW-1:0] miss_cnt_q, miss_cnt_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [3:0]    crash_cnt_q, crash_cnt_d;
  logic          tick_q, tick_d;
  logic          ptr_reset_q, ptr_reset_d;
  logic          play_en_q, play_en_d;
  logic          scare_on_q, scare_on_d;
  logic          win_on_q, win_on_d;
  logic          start_rise;
  logic          crash;
`ifdef GAME_TIMEOUT_EN
  logic [TW-1:0] play_tk_q, play_tk_d;
`endif

  always_comb begin
    // [0],[1] synchronise the raw button; [2] is the edge-detect history
    sync_d      = {sync_q[1:0], bus.start_btn};
    start_rise  = sync_q[1] & ~sync_q[2];
    state_d     = state_q;
    arm_cnt_d   = arm_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    crash_cnt_d = crash_cnt_q;
    crash       = 1'b0;
`ifdef GAME_TIMEOUT_EN
    play_tk_d   = play_tk_q;
`endif

    case (state_q)
      IDLE: begin
        if (start_rise) begin
          state_d   = ARM;
          arm_cnt_d = '0;
        end
      end
      ARM: begin
        if (arm_cnt_q == ARM_LAST) begin
          state_d    = PLAY;
          miss_cnt_d = '0;
          hold_cnt_d = '0;
`ifdef GAME_TIMEOUT_EN
          play_tk_d  = '0;
`endif
        end else begin
          arm_cnt_d = arm_cnt_q + AW'(1);
        end
      end
      PLAY: begin
        if (tick_q) begin
`ifdef GAME_TIMEOUT_EN
          if (play_tk_q != TO_LAST) play_tk_d = play_tk_q + TW'(1);
`endif
          if (bus.lim_win) begin
            state_d = WIN;
`ifdef GAME_TIMEOUT_EN
          end else if (play_tk_q == TO_LAST) begin
            crash = 1'b1;
`endif
          end else if (!bus.lim_ok) begin
            if (miss_cnt_q == MISS_LAST) crash = 1'b1;
            else                         miss_cnt_d = miss_cnt_q + MW'(1);
          end else begin
            miss_cnt_d = '0;
          end
        end
      end
      SCARE, WIN: begin
        if (tick_q) begin
          if (hold_cnt_q == ((state_q == SCARE) ? SCARE_LAST : WIN_LAST)) state_d = IDLE;
          else hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (crash) begin
      state_d = SCARE;
      if (crash_cnt_q != 4'd15) crash_cnt_d = crash_cnt_q + 4'd1;
    end

    // Prescaler is parked at zero during ARM so PLAY starts on a fresh tick period
    div_d       = (state_q == ARM || div_q == DIV_LAST) ? '0 : div_q + DW'(1);
    tick_d      = (state_d != ARM) && (div_d == DIV_LAST);
    ptr_reset_d = (state_d == IDLE) || (state_d == ARM) || (state_d == SCARE);
    play_en_d   = (state_d == PLAY);
    scare_on_d  = (state_d == SCARE);
    win_on_d    = (state_d == WIN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      sync_q      <= '0;
      div_q       <= '0;
      arm_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      hold_cnt_q  <= '0;
      crash_cnt_q <= '0;
      tick_q      <= 1'b0;
      ptr_reset_q <= 1'b1;
      play_en_q   <= 1'b0;
      scare_on_q  <= 1'b0;
      win_on_q    <= 1'b0;
`ifdef GAME_TIMEOUT_EN
      play_tk_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      div_q       <= div_d;
      arm_cnt_q   <= arm_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      crash_cnt_q <= crash_cnt_d;
      tick_q      <= tick_d;
      ptr_reset_q <= ptr_reset_d;
      play_en_q   <= play_en_d;
      scare_on_q  <= scare_on_d;
      win_on_q    <= win_on_d;
`ifdef GAME_TIMEOUT_EN
      play_tk_q   <= play_tk_d;
`endif
    end
  end

  assign bus.state     = state_q;
  assign bus.tick      = tick_q;
  assign bus.crash_cnt = crash_cnt_q;
  assign bus.ptr_reset = ptr_reset_q;
  assign bus.play_en   = play_en_q;
  assign bus.scare_on  = scare_on_q;
  assign bus.win_on    = win_on_q;

endmodule

// File: doc/maze_game_sequencer.md
# maze_game_sequencer

Top-level game controller for the maze pointer datapath. It sequences one round of the game: idle, pointer re-centre, play, then scare (crash) or win display. It drives the pointer's synchronous restart and samples the pointer's in-path (`lim1`) and goal (`lim_W1`) flags on a frame-rate tick. Its outputs select the scare and win overlays in the video mux.

## Interface
Parameters:
- `TICK_DIV`, 900000 — clk cycles per game tick; must be ≥ 2.
- `ARM_CYCLES`, 4 — clk cycles `ptr_reset` is held in ARM; must be ≥ 1.
- `HIT_FILTER`, 3 — consecutive off-path ticks that confirm a crash; must be ≥ 1.
- `SCARE_TICKS`, 180 — ticks the scare image is held.
- `WIN_TICKS`, 120 — ticks the win image is held.
- `TIMEOUT_TICKS`, 3600 — play-time limit in ticks; used only with `GAME_TIMEOUT_EN`.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `start_btn`  in  1  raw start push-button; asynchronous to `clk`.
- `lim_ok`  in  1  pointer fully inside the maze path (pointer `lim1`).
- `lim_win`  in  1  pointer reached the goal row (pointer `lim_W1`).
- `ptr_reset`  out  1  restart request to the pointer (its `reset1`).
- `play_en`  out  1  high only in PLAY.
- `scare_on`  out  1  selects the scare overlay.
- `win_on`  out  1  selects the win overlay.
- `state`  out  3  encoding: IDLE=0, ARM=1, PLAY=2, SCARE=3, WIN=4.
- `tick`  out  1  one-cycle game tick pulse.
- `crash_cnt`  out  4  crashes since reset; saturates at 15.

## Operation
- `start_btn` passes through a 2-flop synchronizer. Rising-edge detection is done on the synchronized signal.
- Prescaler:
  - counts 0..`TICK_DIV`-1 and wraps.
  - `tick`=1 for the single cycle in which the count equals `TICK_DIV`-1.
  - forced to 0 in ARM, so the first PLAY tick arrives `TICK_DIV` cycles after PLAY is entered.
- All outputs are decoded from registered state and counters, with no combinational path from any input:
  - `ptr_reset`=1 in IDLE, ARM and SCARE.
  - `play_en`=1 in PLAY.
  - `scare_on`=1 in SCARE.
  - `win_on`=1 in WIN.
- IDLE → ARM on a start rising edge.
- ARM:
  - the cycle counter runs 0..`ARM_CYCLES`-1.
  - → PLAY on the edge after the counter reaches `ARM_CYCLES`-1.
  - `miss_cnt` and `hold_cnt` are cleared on this transition.
- PLAY (evaluated only in `tick` cycles; inputs are ignored otherwise):
  - if `lim_win`=1 → WIN. Win takes priority over crash and timeout in the same tick.
  - else if `lim_ok`=0: `miss_cnt`+1. If the new value equals `HIT_FILTER` → SCARE.
  - else `miss_cnt` is cleared.
- SCARE:
  - on entry, `crash_cnt` increments, saturating at 15.
  - `hold_cnt` counts ticks; → IDLE on the tick where `hold_cnt` reaches `SCARE_TICKS`-1.
- WIN: same hold as SCARE with `WIN_TICKS`. `ptr_reset`=0, so the pointer stays frozen at the goal.
- A start edge outside IDLE is ignored and discarded; it is not queued.
- Counter widths are `$clog2` of the respective parameter, at minimum 1 bit. No counter wraps past its terminal value.

## Timing
- Reset asserted (low), at any time including mid-round:
  - `state`=IDLE, `ptr_reset`=1.
  - `play_en`, `scare_on`, `win_on`, `tick` = 0.
  - `crash_cnt`, all counters and synchronizer flops = 0.
- Deassertion is synchronous to `clk` via the first flop edge.
- Start latency: with `start_btn` high before rising edge N (N = first `clk` rising edge that samples `start_btn` high), `state`=ARM after edge N+2.
- `ptr_reset` stays high continuously from IDLE through ARM, so the pointer never sees a glitch low.
- Decision latency: a state change out of PLAY is visible one edge after the qualifying `tick` cycle.
- `state` and all decoded outputs change on the same edge.
- SCARE and WIN last exactly `SCARE_TICKS`/`WIN_TICKS` ticks; the first tick counts only if it arrives after entry.

## Configuration
- `GAME_TIMEOUT_EN` defined:
  - a PLAY tick counter is added, cleared on ARM→PLAY.
  - when it reaches `TIMEOUT_TICKS`-1 with no win, → SCARE and `crash_cnt` increments.
  - priority order: win > timeout > crash filter.
- `GAME_TIMEOUT_EN` undefined: no timer logic is present, and PLAY lasts indefinitely.

## Test plan
All scenarios use `TICK_DIV`=4, `ARM_CYCLES`=4, `HIT_FILTER`=3, `SCARE_TICKS`=2, `WIN_TICKS`=2, `TIMEOUT_TICKS`=10.
- Reset then start pulse → `state` 0→1 after edge N+2; ARM lasts 4 cycles; PLAY with `ptr_reset`=0; first `tick` 4 cycles later.
- PLAY, `lim_ok`=0 for 3 ticks → SCARE; `scare_on`=1 for 2 ticks → IDLE; `crash_cnt`=1.
- PLAY, `lim_ok` pattern 0,0,1,0,0 over ticks → stays PLAY; `miss_cnt` cleared at the third tick.
- PLAY, `lim_win`=1 and `lim_ok`=0 in the same tick with `miss_cnt`=2 → WIN, not SCARE; `win_on`=1 for 2 ticks; start presses during WIN are ignored.
- 16 crash rounds → `crash_cnt`=15; reset asserted mid-SCARE → all outputs at reset values immediately.
- `GAME_TIMEOUT_EN` defined, `lim_ok`=1, `lim_win`=0 → SCARE on the 10th PLAY tick. Macro undefined → still PLAY after 20 ticks.
